// File: rtl/cpu_bus_pkg.sv
// Shared cpu_bus definitions: WLEN op codes, address map, arbiter FSM states and request bundle.
// Imported by the arbiter; the address map is kept in step with cpu_bus decode.
package cpu_bus_pkg;

   localparam logic [1:0] WLEN_RD32 = 2'd0;
   localparam logic [1:0] WLEN_WR8  = 2'd1;
   localparam logic [1:0] WLEN_WR16 = 2'd2;
   localparam logic [1:0] WLEN_WR32 = 2'd3;

   localparam logic [31:0] CACHE_START = 32'h0000_0000;
   localparam logic [31:0] LED_START   = 32'h8000_0000;
   localparam logic [31:0] VGA_START   = 32'h8000_1000;
   localparam logic [31:0] KB_START    = 32'h8000_2000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_ACK  = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_COMPLETE  = 3'd4
   } arb_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  wlen;
   } bus_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select; purely combinational, zero latency, no backpressure.
// On a tie the master that did not win last time is chosen.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       win_vld,
   output logic       win
);

   always_comb begin
      win_vld = |req;
      win     = 1'b0;
      case (req)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = ~last_grant;
         default: win = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing cpu_bus between two masters; gnt at T, EN_N low at T+1, done at T+3+N.
// Backpressure: no grant while bus_ready is low; bus waits are bounded by TIMEOUT and end in an error done.
module cpu_bus_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int TO_W    = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [1:0]  m0_wlen,
   output logic        m0_gnt,
   output logic        m0_done,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [1:0]  m1_wlen,
   output logic        m1_gnt,
   output logic        m1_done,
   output logic        m_err,
   output logic [31:0] m_rdata,
   output logic [31:0] bus_address,
   output logic [31:0] bus_wdata,
   output logic [1:0]  bus_wlen,
   output logic        bus_en_n,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   output logic        busy
);

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

   arb_state_t      state, state_nxt;
   bus_req_t        req_q, req_nxt, m0_fields, m1_fields;
   logic            owner, owner_nxt;
   logic            last_grant, last_nxt;
   logic [1:0]      gnt_q, gnt_nxt;
   logic [1:0]      done_q, done_nxt;
   logic            err_q, err_nxt;
   logic            en_n_q, en_n_nxt;
   logic            busy_q;
   logic [31:0]     rdata_q, rdata_nxt;
   logic [TO_W-1:0] cnt_q, cnt_nxt, cnt_inc;
   logic            win_vld, win;

   assign m0_fields = '{addr: m0_addr, wdata: m0_wdata, wlen: m0_wlen};
   assign m1_fields = '{addr: m1_addr, wdata: m1_wdata, wlen: m1_wlen};

   rr_arbiter2 u_rr (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant),
      .win_vld    (win_vld),
      .win        (win)
   );

   always_comb begin
      state_nxt = state;
      req_nxt   = req_q;
      owner_nxt = owner;
      last_nxt  = last_grant;
      gnt_nxt   = 2'b00;
      done_nxt  = 2'b00;
      err_nxt   = 1'b0;
      en_n_nxt  = 1'b1;
      rdata_nxt = rdata_q;
      cnt_nxt   = cnt_q;
      // Saturating count of cycles spent waiting on the bus
      cnt_inc   = (cnt_q == TO_LIMIT) ? cnt_q : cnt_q + TO_W'(1);

      unique case (state)
         ST_IDLE: begin
            if (win_vld && bus_ready) begin
               state_nxt     = ST_ISSUE;
               gnt_nxt[win]  = 1'b1;
               owner_nxt     = win;
               last_nxt      = win;
               req_nxt       = win ? m1_fields : m0_fields;
            end
         end
         ST_ISSUE: begin
            en_n_nxt  = 1'b0;
            cnt_nxt   = '0;
            state_nxt = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            cnt_nxt = cnt_inc;
            if (!bus_ready) begin
               state_nxt = ST_WAIT_DONE;
            end else if (cnt_inc == TO_LIMIT) begin
               state_nxt       = ST_COMPLETE;
               done_nxt[owner] = 1'b1;
               err_nxt         = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            cnt_nxt = cnt_inc;
            if (bus_ready) begin
               state_nxt       = ST_COMPLETE;
               done_nxt[owner] = 1'b1;
               rdata_nxt       = bus_rdata;
            end else if (cnt_inc == TO_LIMIT) begin
               state_nxt       = ST_COMPLETE;
               done_nxt[owner] = 1'b1;
               err_nxt         = 1'b1;
            end
         end
         ST_COMPLETE: state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         req_q      <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         gnt_q      <= 2'b00;
         done_q     <= 2'b00;
         err_q      <= 1'b0;
         en_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         rdata_q    <= '0;
         cnt_q      <= '0;
      end else begin
         state      <= state_nxt;
         req_q      <= req_nxt;
         owner      <= owner_nxt;
         last_grant <= last_nxt;
         gnt_q      <= gnt_nxt;
         done_q     <= done_nxt;
         err_q      <= err_nxt;
         en_n_q     <= en_n_nxt;
         busy_q     <= (state_nxt != ST_IDLE);
         rdata_q    <= rdata_nxt;
         cnt_q      <= cnt_nxt;
      end
   end

   assign m0_gnt      = gnt_q[0];
   assign m1_gnt      = gnt_q[1];
   assign m0_done     = done_q[0];
   assign m1_done     = done_q[1];
   assign m_err       = err_q;
   assign m_rdata     = rdata_q;
   assign bus_address = req_q.addr;
   assign bus_wdata   = req_q.wdata;
   assign bus_wlen    = req_q.wlen;
   assign bus_en_n    = en_n_q;
   assign busy        = busy_q;

endmodule
